// File: rtl/mem_to_uart.sv
// Walks the result memory in row-major order and hands each byte to the UART transmitter.
// Define MEM_TO_UART_ASCII_HEX_EN to send each element as hex text with space/CRLF separators.
module mem_to_uart #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              tx_valid,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     NumElems = ROWS * COLS;
  localparam logic [ADDR_W:0] LastIdx  = (ADDR_W + 1)'(NumElems - 1);
  localparam logic [ADDR_W:0] IdxOne   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StOffer,
    StWaitBusyLow,
    StNext,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] elem_idx_q, elem_idx_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      cur_byte;

`ifdef MEM_TO_UART_ASCII_HEX_EN
  localparam logic [ADDR_W:0] LastCol = (ADDR_W + 1)'(COLS - 1);

  logic [ADDR_W:0] col_idx_q, col_idx_d;
  logic [1:0]      sub_q, sub_d;
  logic            row_end;
  logic            last_sub;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign row_end  = (col_idx_q == LastCol);
  // Row ends carry CR then LF, so they have one more sub-byte than other elements.
  assign last_sub = row_end ? (sub_q == 2'd3) : (sub_q == 2'd2);

  always_comb begin
    cur_byte = 8'h0A;
    case (sub_q)
      2'd0:    cur_byte = hex_char(data_q[7:4]);
      2'd1:    cur_byte = hex_char(data_q[3:0]);
      2'd2:    cur_byte = row_end ? 8'h0D : 8'h20;
      default: cur_byte = 8'h0A;
    endcase
  end
`else
  assign cur_byte = data_q;
`endif

  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    data_d     = data_q;
`ifdef MEM_TO_UART_ASCII_HEX_EN
    col_idx_d  = col_idx_q;
    sub_d      = sub_q;
`endif
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    tx_valid    = 1'b0;
    tx_byte     = '0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        busy = 1'b0;
        done = (state_q == StDone);
        if (start) begin
          state_d    = StRead;
          elem_idx_d = '0;
`ifdef MEM_TO_UART_ASCII_HEX_EN
          col_idx_d  = '0;
`endif
        end
      end
      // Reads wait for an idle transmitter, including one left busy at start.
      StRead: begin
        if (!tx_busy) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = elem_idx_q[ADDR_W-1:0];
          state_d     = StCapture;
        end
      end
      StCapture: begin
        data_d  = mem_rd_data;
        state_d = StOffer;
`ifdef MEM_TO_UART_ASCII_HEX_EN
        sub_d   = 2'd0;
`endif
      end
      StOffer: begin
        tx_valid = 1'b1;
        tx_byte  = cur_byte;
        if (tx_busy) begin
          state_d = StWaitBusyLow;
        end
      end
      StWaitBusyLow: begin
        if (!tx_busy) begin
`ifdef MEM_TO_UART_ASCII_HEX_EN
          if (last_sub) begin
            state_d = StNext;
          end else begin
            sub_d   = sub_q + 2'd1;
            state_d = StOffer;
          end
`else
          state_d = StNext;
`endif
        end
      end
      StNext: begin
        if (elem_idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          elem_idx_d = elem_idx_q + IdxOne;
`ifdef MEM_TO_UART_ASCII_HEX_EN
          col_idx_d  = row_end ? '0 : col_idx_q + IdxOne;
`endif
          state_d    = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      elem_idx_q <= '0;
      data_q     <= '0;
`ifdef MEM_TO_UART_ASCII_HEX_EN
      col_idx_q  <= '0;
      sub_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      data_q     <= data_d;
`ifdef MEM_TO_UART_ASCII_HEX_EN
      col_idx_q  <= col_idx_d;
      sub_q      <= sub_d;
`endif
    end
  end

  rd_needs_idle_tx: assert property (@(posedge clk) disable iff (rst) mem_rd_en |-> !tx_busy);
  byte_stable_while_offered: assert property (@(posedge clk) disable iff (rst)
      (tx_valid && $past(tx_valid)) |-> (tx_byte == $past(tx_byte)));

endmodule

// File: tb/tb_mem_to_uart.sv
// Scoreboard bench for mem_to_uart: a 2x2 instance for the main scenarios and a 3x3 instance.
module tb_mem_to_uart;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A (2x2)
  logic          start_a, rd_en_a, tx_valid_a, busy_a, done_a;
  logic [AW-1:0] rd_addr_a;
  logic [7:0]    rd_data_a = 8'h00;
  logic [7:0]    tx_byte_a;
  logic          model_busy_a = 1'b0;
  logic          hold_busy = 1'b0;
  logic          tx_busy_a;
  int            busy_len_a = 20;
  int            busy_cnt_a = 0;
  int            acc_a = 0;
  logic [7:0]    mem_a [4];
  assign tx_busy_a = model_busy_a | hold_busy;

  // Instance B (3x3)
  logic          start_b, rd_en_b, tx_valid_b, busy_b, done_b;
  logic [AW-1:0] rd_addr_b;
  logic [7:0]    rd_data_b = 8'h00;
  logic [7:0]    tx_byte_b;
  logic          tx_busy_b = 1'b0;
  int            busy_len_b = 3;
  int            busy_cnt_b = 0;
  int            max_addr_b = 0;
  logic [7:0]    mem_b [16];

  logic [7:0]    exp_a[$];
  logic [7:0]    exp_b[$];
  logic [AW-1:0] ea_a[$];
  logic [AW-1:0] ea_b[$];
  logic [7:0]    eb_a, eb_b;
  logic [AW-1:0] ead_a, ead_b;

  mem_to_uart #(.ROWS(2), .COLS(2), .ADDR_W(AW)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .mem_rd_en   (rd_en_a),
    .mem_rd_addr (rd_addr_a),
    .mem_rd_data (rd_data_a),
    .tx_valid    (tx_valid_a),
    .tx_byte     (tx_byte_a),
    .tx_busy     (tx_busy_a),
    .busy        (busy_a),
    .done        (done_a)
  );

  mem_to_uart #(.ROWS(3), .COLS(3), .ADDR_W(AW)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .mem_rd_en   (rd_en_b),
    .mem_rd_addr (rd_addr_b),
    .mem_rd_data (rd_data_b),
    .tx_valid    (tx_valid_b),
    .tx_byte     (tx_byte_b),
    .tx_busy     (tx_busy_b),
    .busy        (busy_b),
    .done        (done_b)
  );

  // Synchronous-read memories and transmitters that stay busy for busy_len clocks per byte.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a[1:0]];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b[3:0]];
    if (tx_valid_a && !tx_busy_a) begin
      model_busy_a <= 1'b1;
      busy_cnt_a   <= busy_len_a;
    end else if (model_busy_a) begin
      if (busy_cnt_a <= 1) model_busy_a <= 1'b0;
      else busy_cnt_a <= busy_cnt_a - 1;
    end
    if (tx_valid_b && !tx_busy_b) begin
      tx_busy_b  <= 1'b1;
      busy_cnt_b <= busy_len_b;
    end else if (tx_busy_b) begin
      if (busy_cnt_b <= 1) tx_busy_b <= 1'b0;
      else busy_cnt_b <= busy_cnt_b - 1;
    end
  end

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitors: pop expectations whenever a DUT offers a byte or issues a read.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid_a && !tx_busy_a) begin
        acc_a++;
        if (exp_a.size() == 0) check("a_tx_extra", 1'b0, 32'(tx_byte_a), 32'h0);
        else begin
          eb_a = exp_a.pop_front();
          check("a_tx_byte", tx_byte_a == eb_a, 32'(tx_byte_a), 32'(eb_a));
        end
      end
      if (rd_en_a) begin
        if (ea_a.size() == 0) check("a_rd_extra", 1'b0, 32'(rd_addr_a), 32'h0);
        else begin
          ead_a = ea_a.pop_front();
          check("a_rd_addr", rd_addr_a == ead_a && !tx_busy_a, 32'(rd_addr_a), 32'(ead_a));
        end
      end
      if (tx_valid_b && !tx_busy_b) begin
        if (exp_b.size() == 0) check("b_tx_extra", 1'b0, 32'(tx_byte_b), 32'h0);
        else begin
          eb_b = exp_b.pop_front();
          check("b_tx_byte", tx_byte_b == eb_b, 32'(tx_byte_b), 32'(eb_b));
        end
      end
      if (rd_en_b) begin
        if (int'(rd_addr_b) > max_addr_b) max_addr_b = int'(rd_addr_b);
        if (ea_b.size() == 0) check("b_rd_extra", 1'b0, 32'(rd_addr_b), 32'h0);
        else begin
          ead_b = ea_b.pop_front();
          check("b_rd_addr", rd_addr_b == ead_b && !tx_busy_b, 32'(rd_addr_b), 32'(ead_b));
        end
      end
    end
  end

  task automatic push_byte(input int which, input logic [7:0] b);
    if (which == 0) exp_a.push_back(b);
    else exp_b.push_back(b);
  endtask

`ifdef MEM_TO_UART_ASCII_HEX_EN
  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n - 4'd10};
  endfunction
`endif

  task automatic push_elem(input int which, input logic [7:0] d, input bit row_end);
`ifdef MEM_TO_UART_ASCII_HEX_EN
    push_byte(which, hexc(d[7:4]));
    push_byte(which, hexc(d[3:0]));
    if (row_end) begin
      push_byte(which, 8'h0D);
      push_byte(which, 8'h0A);
    end else begin
      push_byte(which, 8'h20);
    end
`else
    push_byte(which, d);
`endif
  endtask

  task automatic push_readout_a();
    for (int i = 0; i < 4; i++) begin
      ea_a.push_back(AW'(i));
      push_elem(0, mem_a[i], (i % 2) == 1);
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done(input int which, input string name, input int limit);
    int n = 0;
    if (which == 0) begin
      while (!done_a && n < limit) begin @(negedge clk); n++; end
      check({name, "_done"}, done_a === 1'b1 && busy_a === 1'b0, {30'h0, done_a, busy_a}, 32'h2);
      check({name, "_drained"}, exp_a.size() == 0 && ea_a.size() == 0,
            32'(exp_a.size() + ea_a.size()), 32'h0);
    end else begin
      while (!done_b && n < limit) begin @(negedge clk); n++; end
      check({name, "_done"}, done_b === 1'b1 && busy_b === 1'b0, {30'h0, done_b, busy_b}, 32'h2);
      check({name, "_drained"}, exp_b.size() == 0 && ea_b.size() == 0,
            32'(exp_b.size() + ea_b.size()), 32'h0);
    end
  endtask

  task automatic wait_acc_a(input int target, input int limit);
    int n = 0;
    while (acc_a < target && n < limit) begin @(negedge clk); n++; end
    if (acc_a < target) check("a_accept_timeout", 1'b0, 32'(acc_a), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    logic [7:0] init_b [9] = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F, 8'h5A};
`ifdef MEM_TO_UART_ASCII_HEX_EN
    logic [7:0] asc14 [14] = '{8'h30, 8'h41, 8'h20, 8'h46, 8'h46, 8'h0D, 8'h0A,
                               8'h31, 8'h30, 8'h20, 8'h33, 8'h43, 8'h0D, 8'h0A};
`endif
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mem_a   = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 16; i++) mem_b[i] = 8'hEE;
    for (int i = 0; i < 9; i++) mem_b[i] = init_b[i];
    repeat (3) @(negedge clk);
    check("reset_a", {rd_en_a, rd_addr_a, tx_valid_a, tx_byte_a, busy_a, done_a} == '0,
          32'({rd_en_a, rd_addr_a, tx_valid_a, tx_byte_a, busy_a, done_a}), 32'h0);
    check("reset_b", {rd_en_b, rd_addr_b, tx_valid_b, tx_byte_b, busy_b, done_b} == '0,
          32'({rd_en_b, rd_addr_b, tx_valid_b, tx_byte_b, busy_b, done_b}), 32'h0);
    rst = 1'b0;

    // Basic readout with start-to-offer latency.
`ifdef MEM_TO_UART_ASCII_HEX_EN
    push_readout_a();
`else
    for (int i = 0; i < 4; i++) ea_a.push_back(AW'(i));
    exp_a.push_back(8'h01); exp_a.push_back(8'h02);
    exp_a.push_back(8'h03); exp_a.push_back(8'h04);
`endif
    pulse_start_a();
    check("a_start_read", rd_en_a && busy_a && rd_addr_a == '0, {30'h0, rd_en_a, busy_a}, 32'h3);
    @(posedge clk); #1;
    check("a_capture_idle", !tx_valid_a, {31'h0, tx_valid_a}, 32'h0);
    @(posedge clk); #1;
    check("a_offer_valid", tx_valid_a, {31'h0, tx_valid_a}, 32'h1);
    wait_done(0, "t1", 2000);

    // Second pattern, hand-written bytes.
    mem_a = '{8'h0A, 8'hFF, 8'h10, 8'h3C};
    for (int i = 0; i < 4; i++) ea_a.push_back(AW'(i));
`ifdef MEM_TO_UART_ASCII_HEX_EN
    for (int i = 0; i < 14; i++) exp_a.push_back(asc14[i]);
`else
    exp_a.push_back(8'h0A); exp_a.push_back(8'hFF);
    exp_a.push_back(8'h10); exp_a.push_back(8'h3C);
`endif
    pulse_start_a();
    wait_done(0, "t2", 2000);

    // Transmitter busy before start: no read until it falls.
    hold_busy = 1'b1;
    repeat (20) @(negedge clk);
    push_readout_a();
    pulse_start_a();
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_en_a) bad++;
    end
    check("a_no_rd_while_busy", bad == 0 && busy_a, 32'(bad), 32'h0);
    @(posedge clk); #1;
    hold_busy = 1'b0;
    wait_done(0, "t3", 2000);

    // Start mid-readout is ignored; start in done replays from address 0.
    push_readout_a();
    base = acc_a;
    pulse_start_a();
    wait_acc_a(base + 2, 500);
    pulse_start_a();
    wait_done(0, "t4", 2000);
    push_readout_a();
    pulse_start_a();
    check("a_restart_from_done", !done_a && busy_a, {30'h0, done_a, busy_a}, 32'h1);
    wait_done(0, "t4b", 2000);

    // Asynchronous reset while waiting for the third byte to finish.
    push_readout_a();
    base = acc_a;
    pulse_start_a();
    wait_acc_a(base + 3, 500);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("a_async_rst", {rd_en_a, rd_addr_a, tx_valid_a, tx_byte_a, busy_a, done_a} == '0,
          32'({rd_en_a, rd_addr_a, tx_valid_a, tx_byte_a, busy_a, done_a}), 32'h0);
    exp_a.delete();
    ea_a.delete();
    @(negedge clk);
    rst = 1'b0;
    push_readout_a();
    pulse_start_a();
    wait_done(0, "t5", 2000);

    // 3x3 instance: nine elements, last address 8.
    for (int i = 0; i < 9; i++) begin
      ea_b.push_back(AW'(i));
      push_elem(1, mem_b[i], (i % 3) == 2);
    end
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done(1, "t6", 3000);
    repeat (10) @(negedge clk);
    check("b_last_addr", max_addr_b == 8, 32'(max_addr_b), 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
